// File: rtl/fpu_issue_queue.sv
// Issue/retire wrapper around the combinational half-precision fpu: request FIFO,
// head-entry drive to the fpu, registered response slot and sticky exception flags.
module fpu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [15:0]            req_opA,
  input  logic [15:0]            req_opB,
  input  logic [1:0]             req_op,
  input  logic [TAG_W-1:0]       req_tag,
  output logic [15:0]            fpu_opA,
  output logic [15:0]            fpu_opB,
  output logic [1:0]             fpu_op,
  input  logic [15:0]            fpu_result,
  input  logic                   fpu_overflow,
  input  logic                   fpu_underflow,
  input  logic                   fpu_inexact,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [15:0]            resp_result,
  output logic [TAG_W-1:0]       resp_tag,
  output logic [2:0]             resp_flags,
  output logic [2:0]             sticky_flags,
  input  logic                   flags_clear,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [15:0]      opa_mem [DEPTH];
  logic [15:0]      opb_mem [DEPTH];
  logic [1:0]       op_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          not_empty, push, pop;
  logic [2:0]    new_flags;

  // A full FIFO refuses even while popping: ready looks only at the registered count.
  assign not_empty = (count != '0);
  assign req_ready = (count < FULL_CNT);
  assign push      = req_valid && req_ready;
  assign pop       = not_empty && (!resp_valid || resp_ready);
  assign new_flags = {fpu_overflow, fpu_underflow, fpu_inexact};

  always_ff @(posedge clock) begin
    if (push) begin
      opa_mem[wr_ptr] <= req_opA;
      opb_mem[wr_ptr] <= req_opB;
      op_mem[wr_ptr]  <= req_op;
      tag_mem[wr_ptr] <= req_tag;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Head entry -> fpu (combinational), zeroed while empty
  always_comb begin
    fpu_opA = 16'h0000;
    fpu_opB = 16'h0000;
    fpu_op  = 2'b00;
    if (not_empty) begin
      fpu_opA = opa_mem[rd_ptr];
      fpu_opB = opb_mem[rd_ptr];
      fpu_op  = op_mem[rd_ptr];
    end
  end

  // fpu -> response slot; data fields keep their last value after a drain
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid   <= 1'b0;
      resp_result  <= 16'h0000;
      resp_tag     <= '0;
      resp_flags   <= 3'b000;
      sticky_flags <= 3'b000;
    end else begin
      if (pop) begin
        resp_valid  <= 1'b1;
        resp_result <= fpu_result;
        resp_tag    <= tag_mem[rd_ptr];
        resp_flags  <= new_flags;
      end else if (resp_ready) begin
        resp_valid  <= 1'b0;
      end
      sticky_flags <= (flags_clear ? 3'b000 : sticky_flags) | (pop ? new_flags : 3'b000);
    end
  end

endmodule
